// File: rtl/shape_pkg.sv
// Shared types for the draw-command scheduler: command payload, opcodes and FSM states.
package shape_pkg;

    typedef enum logic {
        OP_FILL   = 1'b0,
        OP_CIRCLE = 1'b1
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [2:0] colour;
        logic [7:0] cx;
        logic [6:0] cy;
        logic [7:0] r;
    } draw_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2
    } sched_state_t;

    localparam int unsigned VGA_W = 160;
    localparam int unsigned VGA_H = 120;

endpackage

// File: rtl/shape_scheduler_cmd_fifo.sv
// Command queue for the shape scheduler; registered pointers, so no fall-through.
module cmd_fifo
    import shape_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  draw_cmd_t din,
    output logic      full,
    input  logic      pop,
    output draw_cmd_t dout,
    output logic      empty
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    draw_cmd_t   r_mem [FIFO_DEPTH];
    logic        w_push;
    logic        w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/shape_scheduler.sv
// Queues fill/circle draw commands and runs them one at a time on the selected engine,
// muxing the running engine's pixel writes onto the VGA port.
module shape_scheduler
    import shape_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [2:0] cmd_colour,
    input  logic [7:0] cmd_centre_x,
    input  logic [6:0] cmd_centre_y,
    input  logic [7:0] cmd_radius,
    output logic       idle,
    output logic [7:0] cmds_done,
    output logic       fill_start,
    output logic [2:0] fill_colour,
    input  logic       fill_done,
    input  logic [7:0] fill_vga_x,
    input  logic [6:0] fill_vga_y,
    input  logic [2:0] fill_vga_colour,
    input  logic       fill_vga_plot,
    output logic       circ_start,
    output logic [2:0] circ_colour,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    input  logic       circ_done,
    input  logic [7:0] circ_vga_x,
    input  logic [6:0] circ_vga_y,
    input  logic [2:0] circ_vga_colour,
    input  logic       circ_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    sched_state_t r_state;
    sched_state_t w_next_state;
    draw_cmd_t    r_cmd;
    draw_cmd_t    w_din;
    draw_cmd_t    w_head;
    logic [7:0]   r_cmds_done;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_sel_done;
    logic         w_done_evt;
    logic         w_run;

    assign w_din = '{op: op_t'(cmd_op), colour: cmd_colour, cx: cmd_centre_x,
                     cy: cmd_centre_y, r: cmd_radius};

    cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   (w_din),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty)
    );

    // Only the engine selected by the latched opcode may end a run.
    assign w_sel_done = (r_cmd.op == OP_CIRCLE) ? circ_done : fill_done;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_done_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_sel_done) begin
                    w_done_evt   = 1'b1;
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_cmds_done <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop)      r_cmd       <= w_head;
            if (w_done_evt) r_cmds_done <= r_cmds_done + 8'd1;
        end
    end

    assign w_run         = (r_state == S_RUN);
    assign fill_start    = w_run && (r_cmd.op == OP_FILL);
    assign circ_start    = w_run && (r_cmd.op == OP_CIRCLE);
    assign fill_colour   = r_cmd.colour;
    assign circ_colour   = r_cmd.colour;
    assign circ_centre_x = r_cmd.cx;
    assign circ_centre_y = r_cmd.cy;
    assign circ_radius   = r_cmd.r;
    assign cmd_ready     = !w_full;
    assign idle          = w_empty && (r_state == S_IDLE);
    assign cmds_done     = r_cmds_done;

    // Outside RUN the port is held quiet so an idle engine can never plot.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (circ_start) begin
            vga_x      = circ_vga_x;
            vga_y      = circ_vga_y;
            vga_colour = circ_vga_colour;
            vga_plot   = circ_vga_plot;
        end else if (fill_start) begin
            vga_x      = fill_vga_x;
            vga_y      = fill_vga_y;
            vga_colour = fill_vga_colour;
            vga_plot   = fill_vga_plot;
        end
    end

endmodule

// File: tb/tb_shape_scheduler.sv
// Self-checking bench for shape_scheduler with behavioural fill/circle engine models.
module tb_shape_scheduler;
    import shape_pkg::*;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_op = 1'b0;
    logic [2:0] cmd_colour = '0;
    logic [7:0] cmd_centre_x = '0;
    logic [6:0] cmd_centre_y = '0;
    logic [7:0] cmd_radius = '0;
    logic       cmd_ready, idle;
    logic [7:0] cmds_done;
    logic       fill_start, circ_start;
    logic [2:0] fill_colour, circ_colour;
    logic [7:0] circ_centre_x, circ_radius;
    logic [6:0] circ_centre_y;
    logic       fill_done, circ_done;
    logic [7:0] fill_vga_x, circ_vga_x, vga_x;
    logic [6:0] fill_vga_y, circ_vga_y, vga_y;
    logic [2:0] fill_vga_colour, circ_vga_colour, vga_colour;
    logic       fill_vga_plot, circ_vga_plot, vga_plot;
    logic       hold_f = 1'b0, hold_c = 1'b0, stray = 1'b0;

    always #5 clk = ~clk;

    shape_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_colour(cmd_colour), .cmd_centre_x(cmd_centre_x),
        .cmd_centre_y(cmd_centre_y), .cmd_radius(cmd_radius),
        .idle(idle), .cmds_done(cmds_done),
        .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
        .fill_vga_x(fill_vga_x), .fill_vga_y(fill_vga_y),
        .fill_vga_colour(fill_vga_colour), .fill_vga_plot(fill_vga_plot),
        .circ_start(circ_start), .circ_colour(circ_colour),
        .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
        .circ_radius(circ_radius), .circ_done(circ_done),
        .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y),
        .circ_vga_colour(circ_vga_colour), .circ_vga_plot(circ_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    // Engine models: plot LEN pixels, raise done (unless held) until start drops.
    // When not started they drive a noise pixel (255,127,7) that must never reach the port.
    logic [3:0] f_cnt, c_cnt;
    logic       f_done_r, c_done_r;

    always @(posedge clk) begin
        if (!rst_n || !fill_start) begin
            f_cnt <= '0; f_done_r <= 1'b0;
        end else if (f_cnt == 4'(LEN)) begin
            if (!hold_f) f_done_r <= 1'b1;
        end else f_cnt <= f_cnt + 4'd1;
    end

    always @(posedge clk) begin
        if (!rst_n || !circ_start) begin
            c_cnt <= '0; c_done_r <= 1'b0;
        end else if (c_cnt == 4'(LEN)) begin
            if (!hold_c) c_done_r <= 1'b1;
        end else c_cnt <= c_cnt + 4'd1;
    end

    assign fill_done       = f_done_r | stray;
    assign fill_vga_plot   = fill_start ? (f_cnt < 4'(LEN)) : 1'b1;
    assign fill_vga_x      = fill_start ? {4'd0, f_cnt} : 8'd255;
    assign fill_vga_y      = fill_start ? 7'd0 : 7'd127;
    assign fill_vga_colour = fill_start ? fill_colour : 3'd7;
    assign circ_done       = c_done_r;
    assign circ_vga_plot   = circ_start ? (c_cnt < 4'(LEN)) : 1'b1;
    assign circ_vga_x      = circ_start ? circ_centre_x + {4'd0, c_cnt} : 8'd255;
    assign circ_vga_y      = circ_start ? circ_centre_y : 7'd127;
    assign circ_vga_colour = circ_start ? circ_colour : 3'd7;

    int        n_vec = 0, n_err = 0;
    int        n_fplot = 0, n_cplot = 0, n_bad = 0;
    logic      p_fs = 1'b0, p_cs = 1'b0;
    draw_cmd_t exp_q[$];

    typedef struct {
        draw_cmd_t cmd;
        logic      exp_ready;
    } vec_t;
    vec_t vt[6];

    function automatic draw_cmd_t mk(input op_t op, input logic [2:0] col,
                                     input logic [7:0] x, input logic [6:0] y,
                                     input logic [7:0] r);
        draw_cmd_t c;
        c.op = op; c.colour = col; c.cx = x; c.cy = y; c.r = r;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and run the start scoreboard and VGA attribution.
    task automatic tick();
        draw_cmd_t a, e;
        @(negedge clk);
        if ((fill_start && !p_fs) || (circ_start && !p_cs)) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL start_unexpected: got fill=%0d circ=%0d expected no start",
                         fill_start, circ_start);
            end else begin
                e = exp_q.pop_front();
                if (e.op == OP_FILL) begin e.cx = '0; e.cy = '0; e.r = '0; end
                a = '0;
                if (circ_start) begin
                    a.op = OP_CIRCLE; a.colour = circ_colour;
                    a.cx = circ_centre_x; a.cy = circ_centre_y; a.r = circ_radius;
                end else begin
                    a.op = OP_FILL; a.colour = fill_colour;
                end
                chk("start_cmd", 32'(a), 32'(e));
                chk("one_start", 32'(fill_start && circ_start), 32'd0);
            end
        end
        if (vga_plot) begin
            if ({vga_x, vga_y, vga_colour} == {8'd255, 7'd127, 3'd7}) n_bad++;
            else if (circ_vga_plot && {vga_x, vga_y, vga_colour} ==
                     {circ_vga_x, circ_vga_y, circ_vga_colour}) n_cplot++;
            else if (fill_vga_plot && {vga_x, vga_y, vga_colour} ==
                     {fill_vga_x, fill_vga_y, fill_vga_colour}) n_fplot++;
            else n_bad++;
        end
        p_fs = fill_start;
        p_cs = circ_start;
    endtask

    task automatic push(input draw_cmd_t c);
        int w = 0;
        cmd_valid = 1'b1; cmd_op = c.op; cmd_colour = c.colour;
        cmd_centre_x = c.cx; cmd_centre_y = c.cy; cmd_radius = c.r;
        while (!cmd_ready && w < 100) begin tick(); w++; end
        if (!cmd_ready) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: got cmd_ready=0 expected 1 within 100 cycles");
        end else exp_q.push_back(c);
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return fill_done;
            1:       return circ_done;
            default: return circ_start;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int w = 0;
        while (!sig(which) && w < 200) begin tick(); w++; end
        if (!sig(which)) begin
            n_vec++; n_err++;
            $display("FAIL %s: got 0 expected 1 within 200 cycles", name);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; hold_f = 1'b0; hold_c = 1'b0; stray = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_fplot = 0; n_cplot = 0; n_bad = 0;
    endtask

    initial begin
        int w;
        vt[0] = '{cmd: mk(OP_CIRCLE, 3'd2, 8'd80,  7'd60,  8'd40), exp_ready: 1'b1};
        vt[1] = '{cmd: mk(OP_FILL,   3'd5, 8'd33,  7'd9,   8'd1),  exp_ready: 1'b1};
        vt[2] = '{cmd: mk(OP_CIRCLE, 3'd7, 8'd10,  7'd20,  8'd5),  exp_ready: 1'b1};
        vt[3] = '{cmd: mk(OP_FILL,   3'd1, 8'd0,   7'd0,   8'd0),  exp_ready: 1'b1};
        vt[4] = '{cmd: mk(OP_CIRCLE, 3'd3, 8'd150, 7'd100, 8'd9),  exp_ready: 1'b0};
        vt[5] = '{cmd: mk(OP_CIRCLE, 3'd6, 8'd30,  7'd110, 8'd70), exp_ready: 1'b0};

        // Reset state
        do_reset();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cmds_done", 32'(cmds_done), 32'd0);
        chk("rst_fill_start", 32'(fill_start), 32'd0);
        chk("rst_circ_start", 32'(circ_start), 32'd0);
        chk("rst_vga_plot", 32'(vga_plot), 32'd0);

        // Single circle: start two cycles after the push edge
        push(vt[0].cmd);
        chk("circ_start_lat1", 32'(circ_start), 32'd0);
        tick();
        chk("circ_start_lat2", 32'(circ_start), 32'd1);
        chk("single_fill_start", 32'(fill_start), 32'd0);
        wait_for(1, "circ_done_wait");
        chk("single_cnt_before", 32'(cmds_done), 32'd0);
        tick();
        chk("single_release_start", 32'(circ_start), 32'd0);
        chk("single_cnt", 32'(cmds_done), 32'd1);
        tick();
        chk("single_idle", 32'(idle), 32'd1);
        chk("single_cplot", 32'(n_cplot), 32'(LEN));
        chk("single_bad_plot", 32'(n_bad), 32'd0);

        // Fill then circle: three cycles from fill_done to circ_start
        do_reset();
        push(mk(OP_FILL, 3'd0, 8'd0, 7'd0, 8'd0));
        push(vt[0].cmd);
        wait_for(0, "fill_done_wait");
        tick();
        chk("gap_c1", 32'({fill_start, circ_start}), 32'd0);
        tick();
        chk("gap_c2", 32'({fill_start, circ_start}), 32'd0);
        tick();
        chk("gap_c3", 32'(circ_start), 32'd1);
        wait_for(1, "circ_done_wait2");
        repeat (2) tick();
        chk("seq_cnt", 32'(cmds_done), 32'd2);
        chk("seq_fplot", 32'(n_fplot), 32'(LEN));
        chk("seq_cplot", 32'(n_cplot), 32'(LEN));
        chk("seq_bad_plot", 32'(n_bad), 32'd0);

        // Back-pressure from the vector table
        do_reset();
        hold_f = 1'b1; hold_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(vt[i].cmd);
            chk($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'(vt[i].exp_ready));
        end
        cmd_valid = 1'b1; cmd_op = vt[5].cmd.op; cmd_colour = vt[5].cmd.colour;
        cmd_centre_x = vt[5].cmd.cx; cmd_centre_y = vt[5].cmd.cy; cmd_radius = vt[5].cmd.r;
        repeat (5) tick();
        chk("bp_held_ready", 32'(cmd_ready), 32'd0);
        chk("bp_held_cnt", 32'(cmds_done), 32'd0);
        chk("bp_held_run", 32'(circ_start), 32'd1);
        hold_f = 1'b0; hold_c = 1'b0;
        push(vt[5].cmd);
        chk("bp_ready5", 32'(cmd_ready), 32'(vt[5].exp_ready));
        w = 0;
        while (cmds_done != 8'd6 && w < 400) begin tick(); w++; end
        repeat (2) tick();
        chk("bp_cnt", 32'(cmds_done), 32'd6);
        chk("bp_idle", 32'(idle), 32'd1);
        chk("bp_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_fplot", 32'(n_fplot), 32'(2 * LEN));
        chk("bp_cplot", 32'(n_cplot), 32'(4 * LEN));
        chk("bp_bad_plot", 32'(n_bad), 32'd0);

        // Stray fill_done during a circle run
        do_reset();
        hold_c = 1'b1;
        push(vt[2].cmd);
        wait_for(2, "stray_start_wait");
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("stray_run", 32'(circ_start), 32'd1);
        chk("stray_fill_start", 32'(fill_start), 32'd0);
        chk("stray_cnt", 32'(cmds_done), 32'd0);
        hold_c = 1'b0;
        wait_for(1, "stray_done_wait");
        repeat (2) tick();
        chk("stray_cnt_end", 32'(cmds_done), 32'd1);

        // Reset mid-draw with two commands queued
        do_reset();
        hold_c = 1'b1;
        push(vt[0].cmd);
        push(vt[2].cmd);
        push(vt[4].cmd);
        tick();
        chk("mid_run", 32'(circ_start), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_rst_start", 32'(circ_start), 32'd0);
        chk("mid_rst_cnt", 32'(cmds_done), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        hold_c = 1'b0;
        repeat (40) tick();
        chk("mid_after_cnt", 32'(cmds_done), 32'd0);
        chk("mid_after_start", 32'({fill_start, circ_start}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shape_scheduler.md
Name: shape_scheduler

Overview:
- Command scheduler between a host (user logic or top-level test FSM) and the two drawing engines: fillscreen and circle.
- Queues draw commands in a small FIFO and runs them one at a time against the selected engine, using the engine start/done handshake.
- Muxes the active engine's VGA pixel-write outputs onto the single VGA adapter port.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  host presents a command
- cmd_ready  out  1  scheduler can accept a command (FIFO not full)
- cmd_op  in  1  0 = fill screen, 1 = circle
- cmd_colour  in  3  draw colour
- cmd_centre_x  in  8  circle centre x; ignored for fill
- cmd_centre_y  in  7  circle centre y; ignored for fill
- cmd_radius  in  8  circle radius; ignored for fill
- idle  out  1  FIFO empty and FSM in IDLE
- cmds_done  out  8  count of completed commands, wraps 255->0
- fill_start  out  1  fillscreen engine start
- fill_colour  out  3  fillscreen colour
- fill_done  in  1  fillscreen done
- fill_vga_x / fill_vga_y / fill_vga_colour / fill_vga_plot  in  8/7/3/1  fillscreen pixel outputs
- circ_start  out  1  circle engine start
- circ_colour / circ_centre_x / circ_centre_y / circ_radius  out  3/8/7/8  circle engine operands
- circ_done  in  1  circle done
- circ_vga_x / circ_vga_y / circ_vga_colour / circ_vga_plot  in  8/7/3/1  circle pixel outputs
- vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  to VGA adapter

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge clears the design.
- Reset values: FIFO empty, FSM IDLE, fill_start=0, circ_start=0, cmds_done=0, vga_plot=0, cmd_ready=1, idle=1, operand registers 0.
- Push: on an edge where cmd_valid && cmd_ready, {op, colour, cx, cy, r} is written at the tail. cmd_ready = !full.
  - Full FIFO: cmd_ready=0; the command is not stored, and the host must hold it.
- No fall-through: a command pushed at edge T is first poppable at edge T+1.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the current-command register and go to RUN.
  - RUN: the selected start (by registered op) is 1; the other start is 0. The engine operand outputs are driven from the current-command register and are stable throughout RUN. When the selected done is 1, go to RELEASE and increment cmds_done.
  - RELEASE: both starts 0 for exactly one cycle, so the engine rearms. Then go to IDLE.
- Engine contract: start is held high until done; the engine clears done after it sees start low.
- Latency:
  - Push at edge T onto an empty FIFO with IDLE: pop at T+1, start high during the cycle after T+1.
  - Back-to-back commands have a gap of 2 cycles with start low between engine runs (RELEASE, then IDLE), plus 1 pop cycle.
- Simultaneous push and pop in IDLE are both honoured. The count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Done from the non-selected engine is ignored. A done already high on the first RUN cycle is accepted, since the engine contract forbids it.
- VGA mux is combinational:
  - In RUN, vga_* = the selected engine's vga_*.
  - Otherwise vga_plot=0 and vga_x/y/colour=0.
  - The non-selected engine's plot never reaches the output.
- idle = FIFO empty && state==IDLE.
- Reset mid-operation: all state clears at the reset edge. Queued commands are discarded, and start drops the following cycle. Engines reset on the same rst_n.
- cmds_done wraps 255 -> 0 with no flag.

Decomposition:
- Package shape_pkg holds:
  - typedef enum logic {OP_FILL, OP_CIRCLE} op_t
  - typedef struct packed {op_t op; logic [2:0] colour; logic [7:0] cx; logic [6:0] cy; logic [7:0] r;} draw_cmd_t (27 bits)
  - typedef enum {S_IDLE, S_RUN, S_RELEASE} sched_state_t
  - constants VGA_W=160, VGA_H=120
- Sub-module cmd_fifo(clk, rst_n, push, din, full, pop, dout, empty), parameterised by FIFO_DEPTH, storing draw_cmd_t.
- shape_scheduler instantiates cmd_fifo and contains the FSM, counter and mux. Engines are instantiated by the top level, not inside this block.

Test Plan:
- Reset then idle: 3 cycles with rst_n=0, then release → idle=1, cmd_ready=1, cmds_done=0, both starts 0, vga_plot=0.
- Single circle: push op=1, colour=2, cx=80, cy=60, r=40 with a real circle engine → circ_start high 2 cycles after push. circ_* operands match. fill_start stays 0. Every vga_plot mirrors circ_vga_*. On circ_done, cmds_done=1, circ_start is low for 1 cycle, idle=1.
- Sequence fill then circle: push fill colour=0, then circle (80,60,40,colour=2) → fill runs to completion first. Exactly 3 cycles separate fill_done from circ_start rising. cmds_done=2 at end. No plot is attributed to the wrong engine.
- Back-pressure: with stub engines holding done=0, push 6 commands → 1 pop into RUN plus 4 queued. cmd_ready=0 after the 5th accept, and the 6th is held until a slot frees. The 6th executes last, in order.
- Stray done: pulse fill_done while a circle runs → no state change and cmds_done unchanged.
- Reset mid-draw: assert rst_n=0 during circle RUN with 2 queued → next cycle circ_start=0, FIFO empty, cmds_done=0. After release no queued command executes.
